serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller: sequences one instance of the 1-bit full adder over

---
 rtl/serial_add_ctrl_pkg.sv | 15 +
 rtl/serial_add_ctrl_if.sv | 31 +++
 rtl/serial_add_ctrl_full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_serial_add_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t    : FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is illegal
//                and recovers to IDLE)
//   DEF_WIDTH  : default operand/result width
package serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Host-side handshake bundle for the bit-serial adder.
//   start        host -> adder  request, sampled only while idle
//   a, b, cin    host -> adder  operands, captured on an accepted start
//   busy         adder -> host  high while an add is running or completing
//   done         adder -> host  one-cycle pulse, sum/cout just updated
//   sum, cout    adder -> host  result, held until the next completion
// Modports: master = host, slave = adder.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell, purely combinational.
//   a, b, cin  : addend bits and carry-in
//   sum, cout  : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Adds two WIDTH-bit operands plus a carry-in,
// LSB first, one bit per clock, through a single full_adder cell. The carry
// lives in a flop between bits.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of serial_add_ctrl_if (start/a/b/cin in,
//            busy/done/sum/cout out)
// Timing: start accepted at edge E0, bits at E1..E_WIDTH, done high for the
// cycle after E_WIDTH, back to IDLE one edge later (one add per WIDTH+2
// cycles). start is ignored whenever busy is high.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc_sr;
  logic             c_ff;
  logic [CW-1:0]    cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_next;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_ff),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Result bits enter at the top and walk down, so after WIDTH shifts the
  // first (LSB) bit sits at index 0.
  assign acc_next = {fa_sum, acc_sr[WIDTH-1:1]};

  // NOTE: every register here, datapath included, is cleared by reset so an
  // aborted add leaves no stale partial result behind; state is updated only
  // with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      acc_sr <= '0;
      c_ff   <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            c_ff   <= bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end
        end

        ST_RUN: begin
          acc_sr <= acc_next;
          c_ff   <= fa_cout;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          if (cnt == LAST_BIT) begin
            // Publish the completed word straight from the adder outputs so
            // done lines up with the result.
            sum_q  <= acc_next;
            cout_q <= fa_cout;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
// Inputs change after the falling edge or 1ns after the rising edge; outputs
// are sampled 1ns after the rising edge.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_pass   = 0;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One add with a single-cycle start pulse. Operands are scrambled right
  // after acceptance; the result must still reflect the captured values.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input logic [7:0] es, input logic ec, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    bus.a = ta; bus.b = tb_; bus.cin = tc; bus.start = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        bus.a = ~ta; bus.b = ~tb_; bus.cin = ~tc;
      end
      if (bus.done) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_sum"},     32'(bus.sum),  32'(es));
    check({tag, "_cout"},    32'(bus.cout), 32'(ec));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_idle"},  32'(bus.busy), 32'd0);
    check({tag, "_sum_held"},   32'(bus.sum),  32'(es));
  endtask

  logic [7:0] opa [3];
  logic [7:0] opb [3];
  logic       opc [3];
  logic [7:0] exs [3];
  logic       exc [3];

  initial begin
    int idx_load;
    int ndone;
    int last_t;
    int cnt_done;
    bit prev_busy;
    bit idle_seen;

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum",  32'(bus.sum),  32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);

    run_add(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "add_3c_42");
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
    run_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "add_a5_5a_c");

    // start held high; next operands presented right after each acceptance.
    opa[0] = 8'h11; opb[0] = 8'h22; opc[0] = 1'b0; exs[0] = 8'h33; exc[0] = 1'b0;
    opa[1] = 8'hF0; opb[1] = 8'h20; opc[1] = 1'b1; exs[1] = 8'h11; exc[1] = 1'b1;
    opa[2] = 8'h7F; opb[2] = 8'h7F; opc[2] = 1'b0; exs[2] = 8'hFE; exc[2] = 1'b0;
    @(negedge clk);
    bus.a = opa[0]; bus.b = opb[0]; bus.cin = opc[0]; bus.start = 1'b1;
    idx_load = 1; ndone = 0; last_t = 0; prev_busy = 1'b0;
    for (int t = 1; t <= 60 && ndone < 3; t++) begin
      @(posedge clk); #1;
      if (bus.busy && !prev_busy) begin
        if (idx_load < 3) begin
          bus.a = opa[idx_load]; bus.b = opb[idx_load]; bus.cin = opc[idx_load];
          idx_load++;
        end else begin
          bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
        end
      end
      if (bus.done) begin
        check($sformatf("cont_sum%0d", ndone),  32'(bus.sum),  32'(exs[ndone]));
        check($sformatf("cont_cout%0d", ndone), 32'(bus.cout), 32'(exc[ndone]));
        check($sformatf("cont_gap%0d", ndone),  32'(t - last_t), (ndone == 0) ? 32'd9 : 32'd10);
        last_t = t;
        ndone++;
      end
      prev_busy = bus.busy;
    end
    check("cont_count", 32'(ndone), 32'd3);
    bus.start = 1'b0;
    idle_seen = 1'b0;
    for (int t = 0; t < 15 && !idle_seen; t++) begin
      @(posedge clk); #1;
      if (!bus.busy) idle_seen = 1'b1;
    end
    check("cont_drain", 32'(idle_seen), 32'd1);

    // Leave a nonzero result behind, then abort the next add mid-run.
    run_add(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "pre_abort");
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sum",  32'(bus.sum),  32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      if (bus.done) cnt_done++;
    end
    check("abort_no_done", 32'(cnt_done), 32'd0);

    run_add(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, "add_80_80_c");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
